stream_prbs_source: RTL and testbench

//  AXI-Stream PRBS-31 pattern source, one independent 32-bit lane per link.

---
 rtl/stream_prbs_source.sv | 202 ++++++++++++++++++++
 tb/tb_stream_prbs_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_prbs_source.sv
// AXI-Stream PRBS-31 (x^31+x^28+1) pattern source, one independent 32-bit lane per 32 bits of TDATA.
// Supports free-run and fixed-length bursts and single-word error injection on lane 0 bit 0.
module stream_prbs_source #(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [30:0] SEED        = 31'h7FFF_FFFF
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [31:0]            burst_len,
    input  logic                   inject_err,
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            words_sent
);

    localparam int NLINKS = TDATA_WIDTH / 32;
    localparam logic [TDATA_WIDTH-1:0] INJ_MASK = {{(TDATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Seed for one lane: base seed (zero replaced by all-ones) rotated left by the lane index.
    function automatic logic [30:0] lane_seed(input int lane);
        logic [30:0] rot;
        rot = (SEED == 31'h0) ? 31'h7FFF_FFFF : SEED;
        for (int k = 0; k < lane; k++) begin
            rot = {rot[29:0], rot[30]};
        end
        return rot;
    endfunction

    // Advance one lane by 32 steps; returns {next_state, word} with bit 0 generated first.
    function automatic logic [62:0] lfsr_step32(input logic [30:0] s);
        logic [30:0] st;
        logic [31:0] w;
        logic        b;
        st = s;
        w  = 32'h0;
        for (int j = 0; j < 32; j++) begin
            b    = st[30] ^ st[27];
            w[j] = b;
            st   = {st[29:0], b};
        end
        return {st, w};
    endfunction

    state_t                    state_r;
    state_t                    state_next_s;
    logic [TDATA_WIDTH-1:0]    tdata_r;
    logic                      tvalid_r;
    logic                      busy_r;
    logic                      done_r;
    logic [31:0]               words_sent_r;
    logic [31*NLINKS-1:0]      lane_state_r;
    logic                      mode_r;
    logic [31:0]               burst_len_r;
    logic                      stop_req_r;
    logic                      inj_flag_r;
    logic                      inj_on_tdata_r;

    logic [31*NLINKS-1:0]      next_state_s;
    logic [31*NLINKS-1:0]      seed_state_s;
    logic [TDATA_WIDTH-1:0]    next_word_s;
    logic [TDATA_WIDTH-1:0]    seed_word_s;
    logic [TDATA_WIDTH-1:0]    loaded_word_s;
    logic                      handshake_s;
    logic                      load_seed_s;
    logic                      load_word_s;
    logic                      consumed_s;
    logic                      inj_flag_next_s;

    genvar g;
    generate
        for (g = 0; g < NLINKS; g++) begin : g_lane
            localparam logic [30:0] LANE_SEED = lane_seed(g);
            logic [62:0] adv_s;
            logic [62:0] seed_adv_s;
            assign adv_s      = lfsr_step32(lane_state_r[31*g +: 31]);
            assign seed_adv_s = lfsr_step32(LANE_SEED);
            assign next_state_s[31*g +: 31] = adv_s[62:32];
            assign next_word_s[32*g +: 32]  = adv_s[31:0];
            assign seed_state_s[31*g +: 31] = seed_adv_s[62:32];
            assign seed_word_s[32*g +: 32]  = seed_adv_s[31:0];
        end
    endgenerate

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        load_seed_s  = 1'b0;
        handshake_s  = tvalid_r & M_AXIS_TREADY & (state_r == ST_RUN);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_seed_s = 1'b1;
                    if (mode && (burst_len == 32'd0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (handshake_s) begin
                    if (mode_r) begin
                        if ((words_sent_r + 32'd1) == burst_len_r) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else if (stop_req_r || stop) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Word selection and injection bookkeeping; a pending inject rides on the next loaded word.
    always_comb begin
        load_word_s = load_seed_s | handshake_s;
        consumed_s  = handshake_s & inj_on_tdata_r;
        if (inj_flag_r) begin
            inj_flag_next_s = ~consumed_s;
        end else begin
            inj_flag_next_s = inject_err;
        end
        if (load_seed_s) begin
            loaded_word_s = seed_word_s;
        end else begin
            loaded_word_s = next_word_s;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r        <= ST_IDLE;
            tvalid_r       <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            words_sent_r   <= 32'd0;
            lane_state_r   <= seed_state_s;
            tdata_r        <= seed_word_s;
            mode_r         <= 1'b0;
            burst_len_r    <= 32'd0;
            stop_req_r     <= 1'b0;
            inj_flag_r     <= 1'b0;
            inj_on_tdata_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tvalid_r   <= (state_next_s == ST_RUN);
            busy_r     <= (state_next_s == ST_RUN);
            done_r     <= (state_next_s == ST_DONE);
            inj_flag_r <= inj_flag_next_s;
            if (load_word_s) begin
                tdata_r        <= inj_flag_next_s ? (loaded_word_s ^ INJ_MASK) : loaded_word_s;
                inj_on_tdata_r <= inj_flag_next_s;
            end else begin
                tdata_r        <= tdata_r;
                inj_on_tdata_r <= inj_on_tdata_r;
            end
            if (load_seed_s) begin
                lane_state_r <= seed_state_s;
                words_sent_r <= 32'd0;
                mode_r       <= mode;
                burst_len_r  <= burst_len;
                stop_req_r   <= 1'b0;
            end else if (handshake_s) begin
                lane_state_r <= next_state_s;
                words_sent_r <= words_sent_r + 32'd1;
                stop_req_r   <= (state_next_s == ST_RUN) && !mode_r && (stop_req_r || stop);
            end else begin
                stop_req_r   <= (state_r == ST_RUN) && !mode_r && (stop_req_r || stop);
            end
        end
    end

    assign M_AXIS_TDATA  = tdata_r;
    assign M_AXIS_TVALID = tvalid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_sent    = words_sent_r;

endmodule

// File: tb/tb_stream_prbs_source.sv
// Directed bench for stream_prbs_source: a 32-bit all-ones-seed instance and a 64-bit seed-1 instance
// share the control inputs; expected words come from hand-derived constants and a small LFSR model.
module tb_stream_prbs_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset, start, stop, mode, inject_err, tready;
    logic [31:0] burst_len;
    logic [31:0] tdata32, ws32;
    logic        tvalid32, busy32, done32;
    logic [63:0] tdata64;
    logic [31:0] ws64;
    logic        tvalid64, busy64, done64;

    stream_prbs_source #(.TDATA_WIDTH(32), .SEED(31'h7FFF_FFFF)) dut (
        .clk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .inject_err(inject_err),
        .M_AXIS_TDATA(tdata32), .M_AXIS_TVALID(tvalid32), .M_AXIS_TREADY(tready),
        .busy(busy32), .done(done32), .words_sent(ws32)
    );

    stream_prbs_source #(.TDATA_WIDTH(64), .SEED(31'h0000_0001)) dut64 (
        .clk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .inject_err(inject_err),
        .M_AXIS_TDATA(tdata64), .M_AXIS_TVALID(tvalid64), .M_AXIS_TREADY(tready),
        .busy(busy64), .done(done64), .words_sent(ws64)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt32 = 0;
    logic [31:0] exp_words [0:31];
    logic [31:0] logged [0:15];

    always @(negedge clk) begin
        if (done32) done_cnt32 <= done_cnt32 + 1;
    end

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [62:0] model_step(input logic [30:0] s);
        logic [30:0] st;
        logic [31:0] w;
        logic        b;
        st = s;
        w  = 32'h0;
        for (int j = 0; j < 32; j++) begin
            b    = st[30] ^ st[27];
            w[j] = b;
            st   = {st[29:0], b};
        end
        return {st, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] len);
        mode      = m;
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Run one burst on the 32-bit instance, checking beats, stall stability and completion.
    task automatic run_burst(input logic [31:0] len, input bit rand_ready, input string tag);
        int          beats, dones, stalls_bad, cyc;
        bit          was_stall;
        logic [31:0] held;
        beats = 0; dones = 0; stalls_bad = 0; was_stall = 1'b0; held = 32'h0;
        pulse_start(1'b1, len);
        for (cyc = 0; cyc < 300; cyc++) begin
            if (was_stall && (tdata32 !== held)) stalls_bad++;
            if (done32) dones++;
            if (dones > 0 && !tvalid32 && !done32) break;
            tready = rand_ready ? (($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0) : 1'b1;
            if (tvalid32 && tready) begin
                if (beats < 16) begin
                    logged[beats] = tdata32;
                    check_value({tag, " beat"}, tdata32, exp_words[beats]);
                end
                beats++;
            end
            was_stall = tvalid32 && !tready;
            held      = tdata32;
            tick();
        end
        check_value({tag, " timeout"}, (cyc < 300), 1);
        check_value({tag, " beats"}, beats, len);
        check_value({tag, " done pulses"}, dones, 1);
        check_value({tag, " stall stable"}, stalls_bad, 0);
        check_value({tag, " words_sent"}, ws32, len);
        check_value({tag, " busy after"}, busy32, 1'b0);
    endtask

    initial begin
        int          beats, inj_idx, diffs, diff_idx, base, cyc;
        logic [31:0] diff_bits, held;
        logic [30:0] s, s0, s1;
        logic [62:0] r;
        logic [31:0] l0w0, l1w0;
        bit          seen_done;

        areset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        inject_err = 1'b0; tready = 1'b0; burst_len = 32'd0;
        s = 31'h7FFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            r = model_step(s);
            exp_words[i] = r[31:0];
            s = r[62:32];
        end
        repeat (3) tick();

        // Reset state, including word 0 of each lane's seed.
        check_value("rst tvalid", tvalid32, 1'b0);
        check_value("rst busy", busy32, 1'b0);
        check_value("rst done", done32, 1'b0);
        check_value("rst words_sent", ws32, 32'd0);
        check_value("rst tdata32", tdata32, 32'h7000_0000);
        check_value("rst tdata64", tdata64, 64'h2400_0000_4800_0000);
        areset = 1'b0;
        tick();

        // Test 1: burst of 4, always ready; first two words hand-derived.
        run_burst(32'd4, 1'b0, "t1");
        check_value("t1 word0", logged[0], 32'h7000_0000);
        check_value("t1 word1", logged[1], 32'h3F00_0000);

        // Test 2: same burst under random backpressure.
        run_burst(32'd4, 1'b1, "t2");

        // Test 3: free-run with a single inject; exactly the following beat differs in bit 0.
        tready = 1'b1;
        pulse_start(1'b0, 32'd0);
        beats = 0; inj_idx = -1; diffs = 0; diff_idx = -1; diff_bits = 32'h0;
        base = done_cnt32;
        for (int c = 0; c < 20; c++) begin
            inject_err = (c == 5);
            if (tvalid32 && tready) begin
                if (c == 5) inj_idx = beats;
                if (tdata32 !== exp_words[beats]) begin
                    diffs++;
                    diff_idx  = beats;
                    diff_bits = tdata32 ^ exp_words[beats];
                end
                beats++;
            end
            tick();
        end
        inject_err = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_value("t3 diff count", diffs, 1);
        check_value("t3 diff index", diff_idx, inj_idx + 1);
        check_value("t3 diff bits", diff_bits, 32'h0000_0001);
        check_value("t3 stopped", tvalid32, 1'b0);
        check_value("t3 words_sent", ws32, beats + 1);
        check_value("t3 no done", done_cnt32 - base, 0);

        // Test 4: 64-bit instance, each lane against its own model.
        s0 = 31'h0000_0001;
        s1 = 31'h0000_0002;
        l0w0 = 32'h0; l1w0 = 32'h0;
        beats = 0;
        pulse_start(1'b1, 32'd3);
        for (cyc = 0; cyc < 20 && beats < 3; cyc++) begin
            if (tvalid64 && tready) begin
                if (beats == 0) begin
                    l0w0 = tdata64[31:0];
                    l1w0 = tdata64[63:32];
                end
                r = model_step(s0);
                check_value("t4 lane0", tdata64[31:0], r[31:0]);
                s0 = r[62:32];
                r = model_step(s1);
                check_value("t4 lane1", tdata64[63:32], r[31:0]);
                s1 = r[62:32];
                beats++;
            end
            tick();
        end
        check_value("t4 beats", beats, 3);
        check_value("t4 lane0 word0", l0w0, 32'h4800_0000);
        check_value("t4 lane1 word0", l1w0, 32'h2400_0000);
        check_value("t4 lanes differ", (l0w0 != l1w0), 1'b1);
        repeat (3) tick();
        check_value("t4 words_sent", ws64, 32'd3);

        // Test 5: stop during a stall holds TVALID and data until the handshake.
        base = done_cnt32;
        tready = 1'b1;
        pulse_start(1'b0, 32'd0);
        repeat (3) tick();
        tready = 1'b0;
        stop = 1'b1;
        held = tdata32;
        tick();
        stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_value("t5 tvalid held", tvalid32, 1'b1);
            check_value("t5 tdata held", tdata32, held);
            tick();
        end
        tready = 1'b1;
        tick();
        check_value("t5 tvalid drop", tvalid32, 1'b0);
        check_value("t5 busy drop", busy32, 1'b0);
        tick();
        check_value("t5 no done", done_cnt32 - base, 0);

        // Test 6: reset mid-burst, replay, then a zero-length burst.
        tready = 1'b1;
        pulse_start(1'b1, 32'd10);
        repeat (3) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        base = done_cnt32;
        check_value("t6 rst tvalid", tvalid32, 1'b0);
        check_value("t6 rst words_sent", ws32, 32'd0);
        check_value("t6 rst done", done32, 1'b0);
        repeat (3) tick();
        check_value("t6 no done after abort", done_cnt32 - base, 0);
        run_burst(32'd2, 1'b0, "t6 replay");
        base = done_cnt32;
        pulse_start(1'b1, 32'd0);
        seen_done = done32;
        check_value("t6 zero done", seen_done, 1'b1);
        check_value("t6 zero tvalid", tvalid32, 1'b0);
        tick();
        check_value("t6 zero done low", done32, 1'b0);
        check_value("t6 zero words_sent", ws32, 32'd0);
        tick();
        check_value("t6 zero single pulse", done_cnt32 - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
